// File: rtl/i2c_txn_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_txn_sequencer
//
// Purpose: turns one register-level I2C request (device, register pointer,
// direction, 1..MAX_LEN bytes) into the primitive command stream executed by
// the downstream I2C bit/byte driver: START, address, register, optional
// repeated START + read address, data bytes, STOP. Write data is pulled in
// over a valid/ready stream and read data is pushed out over another.
// Completion is reported with a one-cycle done pulse and an error flag that
// is set when the target NACKed any written byte.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           host request handshake
//   req_rw/req_dev/req_reg/req_len  request fields (rw: 1 = write, len = n-1)
//   wr_valid/wr_ready/wr_data     write-data stream (wr_ready is a 1-cycle pulse)
//   rd_valid/rd_ready/rd_data     read-data stream
//   done/err                      end-of-transaction pulse and NACK flag
//   eng_cmd_valid/eng_cmd_ready   command handshake to the driver
//   eng_cmd/eng_cmd_byte          command code and byte for WRITE
//   eng_rsp_valid/eng_rsp_byte/eng_rsp_nack  driver response for last command
// ---------------------------------------------------------------------------
module i2c_txn_sequencer #(
    parameter int MAX_LEN = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_rw,
    input  logic [6:0]                 req_dev,
    input  logic [7:0]                 req_reg,
    input  logic [$clog2(MAX_LEN)-1:0] req_len,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [7:0]                 wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [7:0]                 rd_data,
    output logic                       done,
    output logic                       err,
    output logic                       eng_cmd_valid,
    input  logic                       eng_cmd_ready,
    output logic [2:0]                 eng_cmd,
    output logic [7:0]                 eng_cmd_byte,
    input  logic                       eng_rsp_valid,
    input  logic [7:0]                 eng_rsp_byte,
    input  logic                       eng_rsp_nack
);

    localparam int CNT_W = $clog2(MAX_LEN);

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_STOP    = 3'd1;
    localparam logic [2:0] CMD_WRITE   = 3'd2;
    localparam logic [2:0] CMD_RD_ACK  = 3'd3;
    localparam logic [2:0] CMD_RD_NACK = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_REG, S_RSTART, S_DEV_R,
        S_WDATA, S_RDATA, S_RDOUT, S_STOP, S_DONE
    } state_t;

    state_t           state;
    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic             err_latch;
    // Set once this state's command has been presented; cleared by its response.
    logic             issued;

    logic       cmd_state;
    logic       can_issue;
    logic       rsp_hit;
    logic       last_byte;
    logic [2:0] cmd_sel;
    logic [7:0] byte_sel;

    // Command code and byte that the current state would issue. The write
    // state only issues once the host offers a byte, so the byte is taken
    // straight from wr_data at the issue edge.
    always_comb begin
        cmd_sel   = CMD_START;
        byte_sel  = 8'h00;
        cmd_state = 1'b1;
        last_byte = (cnt == len_q);
        case (state)
            S_START, S_RSTART: cmd_sel = CMD_START;
            S_DEV_W: begin cmd_sel = CMD_WRITE; byte_sel = {dev_q, 1'b0}; end
            S_REG:   begin cmd_sel = CMD_WRITE; byte_sel = reg_q;          end
            S_DEV_R: begin cmd_sel = CMD_WRITE; byte_sel = {dev_q, 1'b1}; end
            S_WDATA: begin cmd_sel = CMD_WRITE; byte_sel = wr_data;        end
            S_RDATA: cmd_sel = last_byte ? CMD_RD_NACK : CMD_RD_ACK;
            S_STOP:  cmd_sel = CMD_STOP;
            default: cmd_state = 1'b0;
        endcase
        can_issue = cmd_state && !issued && ((state != S_WDATA) || wr_valid);
        // A response only counts once the command has actually been accepted.
        rsp_hit   = cmd_state && issued && !eng_cmd_valid && eng_rsp_valid;
    end

    // Single FSM with registered outputs. Each command state goes through
    // present -> accepted -> response; the case below only decides where to
    // go once the response for this state's command has arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rw_q          <= 1'b0;
            dev_q         <= '0;
            reg_q         <= '0;
            len_q         <= '0;
            cnt           <= '0;
            err_latch     <= 1'b0;
            issued        <= 1'b0;
            req_ready     <= 1'b1;
            wr_ready      <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            eng_cmd_valid <= 1'b0;
            eng_cmd       <= CMD_START;
            eng_cmd_byte  <= '0;
        end else begin
            wr_ready <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;

            if (can_issue) begin
                eng_cmd_valid <= 1'b1;
                eng_cmd       <= cmd_sel;
                eng_cmd_byte  <= byte_sel;
                issued        <= 1'b1;
                if (state == S_WDATA) begin
                    wr_ready <= 1'b1;
                end
            end else if (eng_cmd_valid && eng_cmd_ready) begin
                eng_cmd_valid <= 1'b0;
            end else if (rsp_hit) begin
                issued <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        rw_q      <= req_rw;
                        dev_q     <= req_dev;
                        reg_q     <= req_reg;
                        len_q     <= req_len;
                        cnt       <= '0;
                        err_latch <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START:  if (rsp_hit) state <= S_DEV_W;
                S_RSTART: if (rsp_hit) state <= S_DEV_R;
                S_DEV_W, S_REG, S_DEV_R: begin
                    if (rsp_hit) begin
                        if (eng_rsp_nack) begin
                            err_latch <= 1'b1;
                            state     <= S_STOP;
                        end else if (state == S_DEV_W) begin
                            state <= S_REG;
                        end else if (state == S_DEV_R) begin
                            state <= S_RDATA;
                        end else begin
                            state <= rw_q ? S_WDATA : S_RSTART;
                        end
                    end
                end
                S_WDATA: begin
                    if (rsp_hit) begin
                        if (eng_rsp_nack) begin
                            err_latch <= 1'b1;
                            state     <= S_STOP;
                        end else if (last_byte) begin
                            state <= S_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_RDATA: begin
                    if (rsp_hit) begin
                        rd_data  <= eng_rsp_byte;
                        rd_valid <= 1'b1;
                        state    <= S_RDOUT;
                    end
                end
                S_RDOUT: begin
                    // The next READ is only issued after the host takes this byte.
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (last_byte) begin
                            state <= S_STOP;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_RDATA;
                        end
                    end
                end
                S_STOP: begin
                    if (rsp_hit) begin
                        done  <= 1'b1;
                        err   <= err_latch;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_sequencer
//
// Directed bench for i2c_txn_sequencer. A small driver model logs every
// accepted command and answers it one cycle later (ACK by default, NACK on a
// chosen command index, read bytes from a table). A write-data source and a
// read-data sink sit on the host streams. All bench-side models sample and
// drive on the falling edge; the main sequence works at posedge + 1.
// ---------------------------------------------------------------------------
module tb_i2c_txn_sequencer;

    localparam logic [2:0] C_START = 3'd0;
    localparam logic [2:0] C_STOP  = 3'd1;
    localparam logic [2:0] C_WRITE = 3'd2;
    localparam logic [2:0] C_RACK  = 3'd3;
    localparam logic [2:0] C_RNACK = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [3:0] req_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       done, err;
    logic       eng_cmd_valid, eng_cmd_ready;
    logic [2:0] eng_cmd;
    logic [7:0] eng_cmd_byte;
    logic       eng_rsp_valid, eng_rsp_nack;
    logic [7:0] eng_rsp_byte;

    i2c_txn_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
        .eng_cmd(eng_cmd), .eng_cmd_byte(eng_cmd_byte),
        .eng_rsp_valid(eng_rsp_valid), .eng_rsp_byte(eng_rsp_byte),
        .eng_rsp_nack(eng_rsp_nack)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Driver model state
    logic [2:0] cmd_log[$];
    logic [7:0] byte_log[$];
    bit         pend = 0;
    bit         was_pend;
    logic [2:0] pend_cmd;
    int         pend_idx;
    int         nack_idx = -1;
    logic [7:0] rd_src[8];
    int         rd_src_idx = 0;
    int         read_cmds = 0;
    bit         spurious = 0;
    int         stop_rsp_cyc = 0;

    // Host stream models
    logic [7:0] wr_src[8];
    int         wr_idx = 0;
    int         wr_n = 0;
    bit         wr_block = 0;
    bit         wr_adv = 0;
    int         wr_pulses = 0;
    logic [7:0] rd_log[$];
    int         accept_cyc = 0;
    int         first_cmd_cyc = 0;
    bit         first_pending = 0;
    int         done_cyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Driver: answers each accepted command exactly one cycle later.
    initial begin
        eng_rsp_valid = 1'b0;
        eng_rsp_nack  = 1'b0;
        eng_rsp_byte  = 8'h00;
        forever begin
            @(negedge clk);
            was_pend      = pend;
            eng_rsp_valid = 1'b0;
            eng_rsp_nack  = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend) begin
                    eng_rsp_valid = 1'b1;
                    if (pend_cmd == C_WRITE && pend_idx == nack_idx) eng_rsp_nack = 1'b1;
                    if (pend_cmd == C_RACK || pend_cmd == C_RNACK) begin
                        eng_rsp_byte = rd_src[rd_src_idx % 8];
                        rd_src_idx++;
                    end
                    if (pend_cmd == C_STOP) stop_rsp_cyc = cyc;
                    pend = 0;
                end else if (spurious) begin
                    eng_rsp_valid = 1'b1;
                    eng_rsp_nack  = 1'b1;
                    eng_rsp_byte  = 8'hEE;
                end
                if (eng_cmd_valid && eng_cmd_ready) begin
                    checkOutput("one_outstanding", 32'(was_pend), 0);
                    cmd_log.push_back(eng_cmd);
                    byte_log.push_back(eng_cmd_byte);
                    if (eng_cmd == C_RACK || eng_cmd == C_RNACK) read_cmds++;
                    pend     = 1;
                    pend_cmd = eng_cmd;
                    pend_idx = cmd_log.size() - 1;
                end
            end
        end
    end

    // Write-data source: holds a byte until the wr_ready pulse takes it.
    initial begin
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (wr_adv) wr_idx++;
            if (wr_ready) wr_pulses++;
            wr_adv   = wr_valid && wr_ready;
            wr_valid = (wr_idx < wr_n) && !wr_block;
            wr_data  = wr_src[wr_idx % 8];
        end
    end

    // Read sink and timing monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                accept_cyc    = cyc;
                first_pending = 1;
            end else if (first_pending && eng_cmd_valid) begin
                first_cmd_cyc = cyc;
                first_pending = 0;
            end
            if (done) done_cyc = cyc;
            if (rd_valid && rd_ready) rd_log.push_back(rd_data);
        end
    end

    task automatic clearLogs();
        cmd_log.delete();
        byte_log.delete();
        rd_log.delete();
        read_cmds  = 0;
        rd_src_idx = 0;
        nack_idx   = -1;
        wr_pulses  = 0;
        wr_idx     = 0;
        wr_n       = 0;
        wr_adv     = 0;
    endtask

    task automatic applyStimulus(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len);
        checkOutput("req_ready_idle", 32'(req_ready), 1);
        req_rw    = rw;
        req_dev   = dev;
        req_reg   = rg;
        req_len   = len;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget, input logic exp_err);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_seen", 32'(done), 1);
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("req_ready_during_done", 32'(req_ready), 0);
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 32'(done), 0);
        checkOutput("req_ready_after_done", 32'(req_ready), 1);
    endtask

    task automatic expectCmd(input int idx, input logic [2:0] c, input logic [7:0] b);
        if (idx < cmd_log.size()) begin
            checkOutput($sformatf("cmd%0d", idx), 32'(cmd_log[idx]), 32'(c));
            if (c == C_WRITE) checkOutput($sformatf("byte%0d", idx), 32'(byte_log[idx]), 32'(b));
        end else begin
            checkOutput($sformatf("cmd%0d_missing", idx), cmd_log.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_rd[4];
        int n;
        int bad;

        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_dev = '0; req_reg = '0; req_len = '0;
        rd_ready = 1'b1; eng_cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 1);
        checkOutput("rst_wr_ready", 32'(wr_ready), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_cmd_valid", 32'(eng_cmd_valid), 0);
        checkOutput("rst_cmd", 32'(eng_cmd), 0);
        checkOutput("rst_cmd_byte", 32'(eng_cmd_byte), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 0x50 reg 0x10, two bytes
        $display("[TB] write 2 bytes");
        clearLogs();
        wr_src[0] = 8'hA5; wr_src[1] = 8'h3C; wr_n = 2;
        applyStimulus(1'b1, 7'h50, 8'h10, 4'd1);
        waitDone(200, 1'b0);
        checkOutput("w_ncmd", cmd_log.size(), 6);
        expectCmd(0, C_START, 8'h00);
        expectCmd(1, C_WRITE, 8'hA0);
        expectCmd(2, C_WRITE, 8'h10);
        expectCmd(3, C_WRITE, 8'hA5);
        expectCmd(4, C_WRITE, 8'h3C);
        expectCmd(5, C_STOP, 8'h00);
        checkOutput("w_wr_pulses", wr_pulses, 2);
        checkOutput("w_first_cmd_latency", first_cmd_cyc - accept_cyc, 2);
        checkOutput("w_done_latency", done_cyc - stop_rsp_cyc, 1);

        // Read 0x68 reg 0x75, three bytes
        $display("[TB] read 3 bytes");
        clearLogs();
        rd_src[0] = 8'h11; rd_src[1] = 8'h22; rd_src[2] = 8'h33;
        applyStimulus(1'b0, 7'h68, 8'h75, 4'd2);
        waitDone(200, 1'b0);
        checkOutput("r_ncmd", cmd_log.size(), 9);
        expectCmd(0, C_START, 8'h00);
        expectCmd(1, C_WRITE, 8'hD0);
        expectCmd(2, C_WRITE, 8'h75);
        expectCmd(3, C_START, 8'h00);
        expectCmd(4, C_WRITE, 8'hD1);
        expectCmd(5, C_RACK, 8'h00);
        expectCmd(6, C_RACK, 8'h00);
        expectCmd(7, C_RNACK, 8'h00);
        expectCmd(8, C_STOP, 8'h00);
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33;
        checkOutput("r_nrd", rd_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < rd_log.size()) checkOutput($sformatf("r_rd%0d", i), 32'(rd_log[i]), 32'(exp_rd[i]));

        // Write with address NACK
        $display("[TB] write with address nack");
        clearLogs();
        wr_src[0] = 8'hA5; wr_src[1] = 8'h3C; wr_n = 2; nack_idx = 1;
        applyStimulus(1'b1, 7'h50, 8'h10, 4'd1);
        waitDone(200, 1'b1);
        checkOutput("n_ncmd", cmd_log.size(), 3);
        expectCmd(0, C_START, 8'h00);
        expectCmd(1, C_WRITE, 8'hA0);
        expectCmd(2, C_STOP, 8'h00);
        checkOutput("n_wr_pulses", wr_pulses, 0);

        // Read four bytes with the host stalling after the first
        $display("[TB] read 4 bytes with rd_ready stall");
        clearLogs();
        rd_src[0] = 8'h01; rd_src[1] = 8'h02; rd_src[2] = 8'h03; rd_src[3] = 8'h04;
        rd_ready = 1'b0;
        applyStimulus(1'b0, 7'h3C, 8'h40, 4'd3);
        n = 0;
        while (rd_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checkOutput("s_rd_valid_seen", 32'(rd_valid), 1);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rd_valid !== 1'b1 || rd_data !== 8'h01) bad++;
        end
        checkOutput("s_rd_held", bad, 0);
        checkOutput("s_reads_during_stall", read_cmds, 1);
        rd_ready = 1'b1;
        waitDone(300, 1'b0);
        checkOutput("s_reads_total", read_cmds, 4);
        checkOutput("s_ncmd", cmd_log.size(), 10);
        expectCmd(8, C_RNACK, 8'h00);
        exp_rd[0] = 8'h01; exp_rd[1] = 8'h02; exp_rd[2] = 8'h03; exp_rd[3] = 8'h04;
        checkOutput("s_nrd", rd_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rd_log.size()) checkOutput($sformatf("s_rd%0d", i), 32'(rd_log[i]), 32'(exp_rd[i]));

        // Write with wr_valid withheld and eng_cmd_ready back-pressure
        $display("[TB] write with wr_valid and eng_cmd_ready stalls");
        clearLogs();
        wr_block = 1;
        wr_src[0] = 8'h5A; wr_n = 1;
        applyStimulus(1'b1, 7'h2A, 8'h01, 4'd0);
        n = 0;
        while (cmd_log.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
        checkOutput("p_reached_wdata", cmd_log.size(), 3);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (eng_cmd_valid !== 1'b0) bad++;
        end
        checkOutput("p_no_cmd_without_wr_valid", bad, 0);
        checkOutput("p_no_wr_ready", wr_pulses, 0);
        eng_cmd_ready = 1'b0;
        wr_block = 0;
        n = 0;
        while (eng_cmd_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checkOutput("p_cmd_valid_seen", 32'(eng_cmd_valid), 1);
        bad = 0;
        repeat (5) begin
            if (eng_cmd_valid !== 1'b1 || eng_cmd !== C_WRITE || eng_cmd_byte !== 8'h5A) bad++;
            @(posedge clk); #1;
        end
        checkOutput("p_cmd_stable", bad, 0);
        eng_cmd_ready = 1'b1;
        waitDone(200, 1'b0);
        checkOutput("p_ncmd", cmd_log.size(), 5);
        expectCmd(1, C_WRITE, 8'h54);
        expectCmd(3, C_WRITE, 8'h5A);
        expectCmd(4, C_STOP, 8'h00);
        checkOutput("p_wr_pulses", wr_pulses, 1);

        // Reset in the middle of a read data command
        $display("[TB] reset during read data");
        clearLogs();
        rd_src[0] = 8'h99;
        applyStimulus(1'b0, 7'h68, 8'h75, 4'd0);
        n = 0;
        while (cmd_log.size() < 5 && n < 100) begin @(posedge clk); #1; n++; end
        eng_cmd_ready = 1'b0;
        n = 0;
        while (!(eng_cmd_valid === 1'b1 && eng_cmd === C_RNACK) && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("x_in_rdata", 32'(eng_cmd), 32'(C_RNACK));
        rst_n = 1'b0;
        #1;
        checkOutput("x_req_ready", 32'(req_ready), 1);
        checkOutput("x_cmd_valid", 32'(eng_cmd_valid), 0);
        checkOutput("x_cmd", 32'(eng_cmd), 0);
        checkOutput("x_rd_data", 32'(rd_data), 0);
        checkOutput("x_rd_valid", 32'(rd_valid), 0);
        checkOutput("x_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        eng_cmd_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("x_req_ready_after", 32'(req_ready), 1);
        clearLogs();
        spurious = 1;
        @(posedge clk); #1;
        spurious = 0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (eng_cmd_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) bad++;
        end
        checkOutput("x_spurious_ignored", bad, 0);
        wr_src[0] = 8'h77; wr_n = 1;
        applyStimulus(1'b1, 7'h50, 8'h20, 4'd0);
        waitDone(200, 1'b0);
        checkOutput("x_ncmd", cmd_log.size(), 5);
        expectCmd(0, C_START, 8'h00);
        expectCmd(1, C_WRITE, 8'hA0);
        expectCmd(2, C_WRITE, 8'h20);
        expectCmd(3, C_WRITE, 8'h77);
        expectCmd(4, C_STOP, 8'h00);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Register-level I2C transaction sequencer sitting directly upstream of the I2C bit/byte driver. Accepts one host request (device address, register pointer, direction, 1–16 data bytes) and breaks it into the primitive command stream the driver executes: START, address byte, register byte, repeated START, data bytes, STOP. Streams write data in and read data out with valid/ready handshakes. Reports completion and NACK errors per transaction.

## Interface
- MAX_LEN, 16: maximum bytes per transaction; `req_len` encodes 1..MAX_LEN as len-1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  sequencer idle, request accepted when both high.
- req_rw  in  1  0 = read, 1 = write.
- req_dev  in  7  7-bit target address.
- req_reg  in  8  register pointer.
- req_len  in  4  byte count minus one.
- wr_valid / wr_ready  in / out  1 / 1  write-data handshake.
- wr_data  in  8  write byte.
- rd_valid / rd_ready  out / in  1 / 1  read-data handshake.
- rd_data  out  8  read byte.
- done  out  1  one-cycle pulse at transaction end.
- err  out  1  valid with `done`: 1 = a NACK aborted the transaction.
- eng_cmd_valid / eng_cmd_ready  out / in  1 / 1  command handshake to driver.
- eng_cmd  out  3  0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NACK.
- eng_cmd_byte  out  8  byte for WRITE.
- eng_rsp_valid  in  1  driver finished the last command (one pulse per command).
- eng_rsp_byte  in  8  received byte (READ_*).
- eng_rsp_nack  in  1  target NACKed a WRITE.

## Operation
- States: IDLE, START, DEV_W, REG, RSTART, DEV_R, WDATA, RDATA, RDOUT, STOP, DONE.
- IDLE: `req_ready`=1. On accept, latch rw/dev/reg/len, clear byte counter `cnt` (4 bit) and error latch, go START.
- Every command state: issue exactly one command, then wait for `eng_rsp_valid`; never more than one command outstanding.
- START → DEV_W (WRITE {dev,0}) → REG (WRITE reg) → write: WDATA; read: RSTART (START) → DEV_R (WRITE {dev,1}) → RDATA.
- WDATA: command not issued until `wr_valid`; `wr_ready` pulses one cycle when the byte is taken into the command. After response, `cnt==len` → STOP else `cnt+1`, repeat.
- RDATA: READ_ACK when `cnt!=len`, READ_NACK on last byte. On response capture `eng_rsp_byte`, go RDOUT.
- RDOUT: `rd_valid`=1 until `rd_ready`; then `cnt==len` → STOP else `cnt+1`, RDATA. No further READ issued while a byte is unaccepted.
- Any WRITE response with `eng_rsp_nack`=1 (DEV_W, REG, DEV_R, WDATA): set error latch, go STOP; remaining bytes skipped, no wr_ready/rd_valid for them. `eng_rsp_nack` ignored on START/STOP/READ.
- STOP: issue STOP, on response → DONE. DONE: `done`=1, `err`=latch, for one cycle → IDLE.
- `eng_rsp_valid` while no command is outstanding: ignored.
- Reset mid-transaction: immediate return to IDLE, no STOP issued (driver reset alongside), pending data dropped.

## Timing
- Reset values: req_ready=1 (from IDLE), wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0, eng_cmd_valid=0, eng_cmd=0, eng_cmd_byte=0.
- All outputs registered. `eng_cmd_valid` rises the cycle after state entry, held with stable `eng_cmd`/`eng_cmd_byte` until the `eng_cmd_ready` cycle, low the next cycle.
- Response may arrive the cycle after acceptance at the earliest; next state entered the cycle after `eng_rsp_valid`.
- Request accept → first `eng_cmd_valid`: 2 cycles. Final STOP response → `done`: 1 cycle; `req_ready` high the cycle after `done`.
- `rd_data` valid with `rd_valid`, stable until handshake.
- Minimum write of N bytes: 4+N commands; read of N bytes: 6+N commands.

## Test plan
- Write dev 0x50, reg 0x10, len 1 (2 bytes 0xA5,0x3C), driver ACKs, 0-wait ready → commands START, W 0xA0, W 0x10, W 0xA5, W 0x3C, STOP; done=1, err=0.
- Read dev 0x68, reg 0x75, len 2, driver returns 0x11,0x22,0x33 → START, W 0xD0, W 0x75, START, W 0xD1, READ_ACK, READ_ACK, READ_NACK, STOP; rd_data 0x11,0x22,0x33 in order.
- Write with NACK on DEV_W → next command STOP, no wr_ready pulses, done with err=1.
- Read len 3 with rd_ready held low 20 cycles after first byte → no second READ issued during stall, all 4 bytes delivered once.
- wr_valid withheld 10 cycles at WDATA → eng_cmd_valid stays low; eng_cmd_ready held low 5 cycles → command fields stable throughout.
- Reset asserted during RDATA → all outputs at reset values asynchronously, req_ready=1 after release; spurious eng_rsp_valid in IDLE has no effect.
